vga_sync_decoder: RTL

- Receive-side counterpart of the VGA timing generators.
- Samples incoming active-low hsync/vsync, one pixel per clk, and recovers horizontal/vertical position, an active-video flag and frame/line strobes.
- Measures line and frame periods against the configured mode and declares lock after consecutive good frames.
- Sits in front of the capture/compare logic that checks the display path; default mode is 640x480@60.

---
 rtl/vga_sync_decoder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
//
// Receive-side VGA timing recovery. Samples active-low hsync/vsync once per
// pixel clock, rebuilds the horizontal/vertical position, measures line and
// frame periods against the configured mode and declares lock after
// LOCK_FRAMES consecutive clean frames.
//
// Ports:
//   clk              pixel clock
//   reset_n          synchronous active-low reset
//   hsync_in         horizontal sync, active low
//   vsync_in         vertical sync, active low
//   x_pos            visible column while active, else 0
//   y_pos            visible row while active, else 0
//   active           visible pixel and locked
//   line_start       one-cycle pulse per hsync falling edge
//   frame_start      one-cycle pulse per vsync falling edge
//   locked           timing is locked to the configured mode
//   timing_error     one-cycle pulse on a period mismatch or line timeout
//   measured_h_total last measured line period, clocks
//   measured_v_total last measured frame period, lines
// ---------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter int H_VISIBLE_AREA = 640,
  parameter int H_FRONT_PORCH  = 16,
  parameter int H_SYNC_PULSE   = 96,
  parameter int H_BACK_PORCH   = 48,
  parameter int V_VISIBLE_AREA = 480,
  parameter int V_FRONT_PORCH  = 10,
  parameter int V_SYNC_PULSE   = 2,
  parameter int V_BACK_PORCH   = 33,
  parameter int LOCK_FRAMES    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [10:0] x_pos,
  output logic [10:0] y_pos,
  output logic        active,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_error,
  output logic [10:0] measured_h_total,
  output logic [10:0] measured_v_total
);

  localparam int H_TOTAL = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int V_TOTAL = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

  localparam logic [11:0] H_TOTAL_12  = 12'(H_TOTAL);
  localparam logic [11:0] V_TOTAL_12  = 12'(V_TOTAL);
  localparam logic [10:0] H_ACT_FIRST = 11'(H_SYNC_PULSE + H_BACK_PORCH);
  localparam logic [10:0] H_ACT_LAST  = 11'(H_SYNC_PULSE + H_BACK_PORCH + H_VISIBLE_AREA - 1);
  localparam logic [10:0] V_ACT_FIRST = 11'(V_SYNC_PULSE + V_BACK_PORCH);
  localparam logic [10:0] V_ACT_LAST  = 11'(V_SYNC_PULSE + V_BACK_PORCH + V_VISIBLE_AREA - 1);
  localparam logic [10:0] CNT_MAX     = 11'h7FF;
  localparam logic [3:0]  LOCK_TARGET = 4'(LOCK_FRAMES);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic        hs_d, vs_d;
  logic [10:0] h_cnt, v_cnt;
  logic        h_seen, v_seen, line_bad;
  logic [3:0]  good_cnt, good_nxt;
  logic [1:0]  state, state_nxt;

  logic        h_edge, v_edge;
  logic [11:0] h_period, v_period;
  logic        h_err, v_err, h_timeout, good_frame;
  logic        h_win, v_win, win_active;
  logic        err_pulse, drop_seen;

  assign h_edge = hs_d & ~hsync_in;
  assign v_edge = vs_d & ~vsync_in;

  // Periods are formed one bit wider so a saturated count of 2047 gives 2048
  // and can never alias onto a legal total.
  assign h_period = {1'b0, h_cnt} + 12'd1;
  assign v_period = {1'b0, v_cnt} + 12'd1;

  assign h_err      = h_edge & h_seen & (h_period != H_TOTAL_12);
  assign v_err      = v_edge & v_seen & (v_period != V_TOTAL_12);
  // Fires on the single cycle the counter steps onto 2047, not while parked there.
  assign h_timeout  = ~h_edge & (h_cnt == CNT_MAX - 11'd1);
  assign good_frame = v_edge & v_seen & ~v_err & ~line_bad;

  assign h_win      = (h_cnt >= H_ACT_FIRST) && (h_cnt <= H_ACT_LAST);
  assign v_win      = (v_cnt >= V_ACT_FIRST) && (v_cnt <= V_ACT_LAST);
  assign locked     = (state == ST_LOCKED);
  assign win_active = h_win & v_win & locked;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a value held and no latch is inferred.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    err_pulse = 1'b0;
    drop_seen = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (v_edge) begin
          state_nxt = ST_TRACK;
          good_nxt  = '0;
        end
      end
      ST_TRACK, ST_LOCKED: begin
        if (h_timeout) begin
          err_pulse = 1'b1;
          drop_seen = 1'b1;
          state_nxt = ST_SEARCH;
          good_nxt  = '0;
        end else if (h_err | v_err) begin
          err_pulse = 1'b1;
          good_nxt  = '0;
          state_nxt = ST_TRACK;
        end else if ((state == ST_TRACK) && good_frame) begin
          good_nxt = good_cnt + 4'd1;
          if (good_nxt == LOCK_TARGET) state_nxt = ST_LOCKED;
        end
      end
      default: state_nxt = ST_SEARCH;
    endcase
  end

  // NOTE: clocked state is written with non-blocking assignments so every
  // register sees the pre-edge values of the others, whatever the order here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // The sync delays load the asserted level: a sync held low through
      // reset must be seen high once before its fall counts as an edge.
      hs_d             <= 1'b0;
      vs_d             <= 1'b0;
      h_cnt            <= '0;
      v_cnt            <= '0;
      h_seen           <= 1'b0;
      v_seen           <= 1'b0;
      line_bad         <= 1'b0;
      good_cnt         <= '0;
      state            <= ST_SEARCH;
      x_pos            <= '0;
      y_pos            <= '0;
      active           <= 1'b0;
      line_start       <= 1'b0;
      frame_start      <= 1'b0;
      timing_error     <= 1'b0;
      measured_h_total <= '0;
      measured_v_total <= '0;
    end else begin
      hs_d <= hsync_in;
      vs_d <= vsync_in;

      if (h_edge)                h_cnt <= '0;
      else if (h_cnt != CNT_MAX) h_cnt <= h_cnt + 11'd1;

      // A vsync edge wins over a coincident hsync edge.
      if (v_edge)                          v_cnt <= '0;
      else if (h_edge && v_cnt != CNT_MAX) v_cnt <= v_cnt + 11'd1;

      if (drop_seen)   h_seen <= 1'b0;
      else if (h_edge) h_seen <= 1'b1;
      if (drop_seen)   v_seen <= 1'b0;
      else if (v_edge) v_seen <= 1'b1;

      // Any bad line spoils the frame in progress; each new frame starts clean.
      if (v_edge)     line_bad <= 1'b0;
      else if (h_err) line_bad <= 1'b1;

      if (h_edge && h_seen) measured_h_total <= h_period[10:0];
      if (v_edge && v_seen) measured_v_total <= v_period[10:0];

      state        <= state_nxt;
      good_cnt     <= good_nxt;
      timing_error <= err_pulse;
      line_start   <= h_edge;
      frame_start  <= v_edge;
      active       <= win_active;
      x_pos        <= win_active ? h_cnt - H_ACT_FIRST : 11'd0;
      y_pos        <= win_active ? v_cnt - V_ACT_FIRST : 11'd0;
    end
  end

endmodule
